ervp_onehot_lane_collector: RTL and testbench

ERVP_ONEHOT_LANE_COLLECTOR -- requirements
Module: ERVP_ONEHOT_LANE_COLLECTOR

---
 rtl/ervp_onehot_lane_collector.sv | 84 ++++++++
 tb/tb_ervp_onehot_lane_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ervp_onehot_lane_collector.sv
// Packs a stream of narrow elements into one wide word, steering each accepted
// element to the lane named by a rotating one-hot pointer.
module ervp_onehot_lane_collector #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int NUM_LANE      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              clear,
  input  logic                              sinput_valid,
  input  logic [ELEMENT_WIDTH-1:0]          sinput_data,
  input  logic                              sinput_last,
  output logic                              sinput_ready,
  output logic                              moutput_valid,
  output logic [NUM_LANE*ELEMENT_WIDTH-1:0] moutput_data,
  output logic [NUM_LANE-1:0]               moutput_mask,
  input  logic                              moutput_ready,
  output logic [NUM_LANE-1:0]               lane_select
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t state;
  state_t state_next;

  logic in_hs;
  logic out_hs;
  logic [NUM_LANE-1:0] lane_rot;

  assign in_hs  = sinput_valid & sinput_ready;
  assign out_hs = moutput_valid & moutput_ready;

  // Shift-or rotate keeps the single-lane build legal: the left shift drops to
  // zero and the right shift by zero returns the pointer unchanged.
  assign lane_rot = (lane_select << 1) | (lane_select >> (NUM_LANE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (enable) begin
      if (clear) begin
        state_next = FILL;
      end else begin
        case (state)
          FILL: if (in_hs && (lane_select[NUM_LANE-1] || sinput_last)) state_next = HOLD;
          HOLD: if (out_hs) state_next = FILL;
          default: state_next = FILL;
        endcase
      end
    end
  end

  always_comb begin
    sinput_ready  = enable & ~clear & (state == FILL);
    moutput_valid = enable & (state == HOLD);
  end

  // Handshakes are mutually exclusive because each is qualified by a different state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_select  <= NUM_LANE'(1);
      moutput_mask <= '0;
      moutput_data <= '0;
    end else if (enable) begin
      if (clear || out_hs) begin
        lane_select  <= NUM_LANE'(1);
        moutput_mask <= '0;
        moutput_data <= '0;
      end else if (in_hs) begin
        for (int k = 0; k < NUM_LANE; k++) begin
          if (lane_select[k]) moutput_data[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= sinput_data;
        end
        moutput_mask <= moutput_mask | lane_select;
        lane_select  <= lane_rot;
      end
    end
  end

endmodule

// File: tb/tb_ervp_onehot_lane_collector.sv
// Directed checks of the lane collector with a 4-lane, 8-bit configuration.
module tb_ervp_onehot_lane_collector;

  localparam int EW = 8;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear;
  logic          sinput_valid;
  logic [EW-1:0] sinput_data;
  logic          sinput_last;
  logic          sinput_ready;
  logic          moutput_valid;
  logic [NL*EW-1:0] moutput_data;
  logic [NL-1:0] moutput_mask;
  logic          moutput_ready;
  logic [NL-1:0] lane_select;

  int checks = 0;
  int errors = 0;

  ervp_onehot_lane_collector #(.ELEMENT_WIDTH(EW), .NUM_LANE(NL)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .clear(clear),
    .sinput_valid(sinput_valid),
    .sinput_data(sinput_data),
    .sinput_last(sinput_last),
    .sinput_ready(sinput_ready),
    .moutput_valid(moutput_valid),
    .moutput_data(moutput_data),
    .moutput_mask(moutput_mask),
    .moutput_ready(moutput_ready),
    .lane_select(lane_select)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic apply_stimulus(input logic v, input logic [EW-1:0] d, input logic last,
                                input logic ordy, input logic en, input logic clr);
    sinput_valid  = v;
    sinput_data   = d;
    sinput_last   = last;
    moutput_ready = ordy;
    enable        = en;
    clear         = clr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    step();
    step();
    rst = 1'b0;
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("reset_valid", 32'(moutput_valid), 32'h0);
    check_output("reset_ready", 32'(sinput_ready), 32'h1);
    check_output("reset_mask", 32'(moutput_mask), 32'h0);
    check_output("reset_data", moutput_data, 32'h0);
    check_output("reset_lane", 32'(lane_select), 32'h1);

    // Full group of four back-to-back elements
    apply_stimulus(1, 8'h11, 0, 0, 1, 0);
    step();
    apply_stimulus(1, 8'h22, 0, 0, 1, 0);
    check_output("full_lane1", 32'(lane_select), 32'h2);
    check_output("full_mask1", 32'(moutput_mask), 32'h1);
    step();
    apply_stimulus(1, 8'h33, 0, 0, 1, 0);
    step();
    apply_stimulus(1, 8'h44, 0, 0, 1, 0);
    check_output("full_lane3", 32'(lane_select), 32'h8);
    check_output("full_ready3", 32'(sinput_ready), 32'h1);
    step();
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("full_valid", 32'(moutput_valid), 32'h1);
    check_output("full_data", moutput_data, 32'h44332211);
    check_output("full_mask", 32'(moutput_mask), 32'hF);
    check_output("full_ready", 32'(sinput_ready), 32'h0);

    // Backpressure: five held cycles, with valid input offered that must be refused
    for (int i = 0; i < 5; i++) begin
      step();
      apply_stimulus(1, 8'h5A, 0, 0, 1, 0);
      check_output("bp_valid", 32'(moutput_valid), 32'h1);
      check_output("bp_data", moutput_data, 32'h44332211);
      check_output("bp_mask", 32'(moutput_mask), 32'hF);
      check_output("bp_ready", 32'(sinput_ready), 32'h0);
    end
    apply_stimulus(1, 8'h5A, 0, 1, 1, 0);
    check_output("bp_release_valid", 32'(moutput_valid), 32'h1);
    check_output("bp_release_ready", 32'(sinput_ready), 32'h0);
    step();
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("bp_after_valid", 32'(moutput_valid), 32'h0);
    check_output("bp_after_ready", 32'(sinput_ready), 32'h1);
    check_output("bp_after_mask", 32'(moutput_mask), 32'h0);
    check_output("bp_after_data", moutput_data, 32'h0);
    check_output("bp_after_lane", 32'(lane_select), 32'h1);

    // Early completion via sinput_last
    apply_stimulus(1, 8'hAA, 0, 0, 1, 0);
    step();
    apply_stimulus(1, 8'hBB, 1, 0, 1, 0);
    step();
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("last_valid", 32'(moutput_valid), 32'h1);
    check_output("last_data", moutput_data, 32'h0000BBAA);
    check_output("last_mask", 32'(moutput_mask), 32'h3);
    check_output("last_lane", 32'(lane_select), 32'h4);
    apply_stimulus(0, 8'h00, 0, 1, 1, 0);
    step();
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("last_after_lane", 32'(lane_select), 32'h1);
    check_output("last_after_valid", 32'(moutput_valid), 32'h0);

    // Clear mid-group drops the offered element
    apply_stimulus(1, 8'h01, 0, 0, 1, 0);
    step();
    apply_stimulus(1, 8'h02, 0, 0, 1, 0);
    step();
    apply_stimulus(1, 8'h03, 0, 0, 1, 1);
    check_output("clr_ready", 32'(sinput_ready), 32'h0);
    step();
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("clr_mask", 32'(moutput_mask), 32'h0);
    check_output("clr_data", moutput_data, 32'h0);
    check_output("clr_lane", 32'(lane_select), 32'h1);
    check_output("clr_valid", 32'(moutput_valid), 32'h0);

    // New group after clear, with enable gated off for three cycles mid-group
    apply_stimulus(1, 8'h05, 0, 0, 1, 0);
    step();
    apply_stimulus(1, 8'h06, 0, 0, 1, 0);
    check_output("gate_mask0", 32'(moutput_mask), 32'h1);
    check_output("gate_data0", moutput_data, 32'h00000005);
    step();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 8'h99, 0, 1, 0, 0);
      check_output("gate_ready", 32'(sinput_ready), 32'h0);
      check_output("gate_valid", 32'(moutput_valid), 32'h0);
      check_output("gate_lane", 32'(lane_select), 32'h4);
      check_output("gate_mask", 32'(moutput_mask), 32'h3);
      step();
    end
    apply_stimulus(1, 8'h07, 0, 0, 1, 0);
    check_output("gate_resume_lane", 32'(lane_select), 32'h4);
    check_output("gate_resume_data", moutput_data, 32'h00000605);
    step();
    apply_stimulus(1, 8'h08, 0, 0, 1, 0);
    step();
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("gate_full_valid", 32'(moutput_valid), 32'h1);
    check_output("gate_full_data", moutput_data, 32'h08070605);
    check_output("gate_full_mask", 32'(moutput_mask), 32'hF);

    // Enable low in HOLD hides valid and ignores a ready downstream
    apply_stimulus(0, 8'h00, 0, 1, 0, 1);
    check_output("hold_gate_valid", 32'(moutput_valid), 32'h0);
    step();
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("hold_gate_kept_valid", 32'(moutput_valid), 32'h1);
    check_output("hold_gate_kept_data", moutput_data, 32'h08070605);

    // Reset while holding a packed word
    rst = 1'b1;
    apply_stimulus(1, 8'hEE, 0, 1, 1, 0);
    step();
    rst = 1'b0;
    apply_stimulus(0, 8'h00, 0, 0, 1, 0);
    check_output("rst_hold_valid", 32'(moutput_valid), 32'h0);
    check_output("rst_hold_mask", 32'(moutput_mask), 32'h0);
    check_output("rst_hold_data", moutput_data, 32'h0);
    check_output("rst_hold_lane", 32'(lane_select), 32'h1);
    check_output("rst_hold_ready", 32'(sinput_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
